ram_arbiter_2p: RTL
===================

# ram_arbiter_2p

Two-requester arbiter and sequencer in front of the 8 KB dual-bank word RAM (two 4 KB banks, bank selected by address bit 10). It lets two masters share the single RAM port, typically M0 = CPU data bus and M1 = DMA/housekeeping engine. It accepts one access at a time, drives the RAM's enable, byte-write, data and address lines from registers, and returns read data with a one-cycle ready pulse. Bank decode stays inside the RAM; this block passes the full word address through.

## Interface
- AW, 11, word address width (bit AW-1 selects the bank inside the RAM)
- DW, 32, data width; byte-write width is DW/8
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- M0_REQ  in  1  M0 access request; held high until M0_RDY
- M0_WE  in  DW/8  M0 byte write enables; 0 = read
- M0_A  in  AW  M0 word address
- M0_DI  in  DW  M0 write data
- M0_DO  out  DW  M0 read data; valid only while M0_RDY=1
- M0_RDY  out  1  one-cycle completion pulse to M0
- M1_REQ, M1_WE, M1_A, M1_DI, M1_DO, M1_RDY: same as M0 for requester 1
- RAM_EN  out  1  RAM enable, registered
- RAM_WE  out  DW/8  RAM byte writes, registered
- RAM_A  out  AW  RAM address, registered
- RAM_DI  out  DW  RAM write data, registered
- RAM_DO  in  DW  RAM read data, valid the cycle after the edge that sampled RAM_EN=1

## Operation
- States: IDLE, ISSUE, DATA. Register GNT (0/1) records the current owner. Register LAST records the previous winner.
- IDLE: if either REQ=1 at a rising edge, pick a winner. Load RAM_EN=1, RAM_WE/RAM_A/RAM_DI from the winner, and GNT=winner. Go to ISSUE. If no request, hold all RAM_* outputs at 0 (RAM_EN=0, RAM_WE=0).
- ISSUE: the RAM samples its inputs at the next edge. At that edge, clear RAM_EN and RAM_WE to 0 and go to DATA.
- DATA: drive RDY[GNT]=1. Drive DO[GNT]=RAM_DO for reads and for writes (write data is don't-care). At the next edge, go to IDLE. No new arbitration occurs in DATA.
- Requester rule: REQ, WE, A and DI stay stable from assertion until the cycle in which RDY=1. The requester may drop REQ or present a new request after that edge.
- Arbitration: a lone requester always wins. When both request, the winner is set by the configuration below. Update LAST on every grant.
- The non-granted requester's DO is driven to 0 and its RDY to 0.
- RAM_EN is high for exactly one clock per access. RAM_WE is never nonzero while RAM_EN=0.
- Reset values: state=IDLE, GNT=0, LAST=1, RAM_EN=0, RAM_WE=0, RAM_A=0, RAM_DI=0, M0_RDY=M1_RDY=0, M0_DO=M1_DO=0.
- Reset mid-access: return to IDLE immediately and emit no RDY. A write already sampled by the RAM stays written. A requester still holding REQ after reset is re-arbitrated normally.
- Address wrap: none; the address passes through unmodified. The bank boundary at 0x400 (bit 10) is invisible to the arbiter.

## Timing
- Request sampled at edge k (state IDLE) -> RAM_EN=1 during cycle k..k+1 -> RAM captures at edge k+1 -> RDY=1 and DO valid during cycle k+1..k+2.
- Latency is 2 cycles from the sampling edge to RDY.
- Throughput is one access per 3 cycles (IDLE, ISSUE, DATA).
- A requester that keeps REQ high after RDY is treated as a new request at the IDLE edge (edge k+2).
- Simultaneous requests at the same edge resolve in the same cycle. The loser waits in its held state with no extra penalty beyond the winner's access.

## Configuration
- RAM_ARB_RR_EN defined: round-robin. On a tie, the winner is the requester other than LAST, so neither master can be starved by back-to-back requests from the other.
- RAM_ARB_RR_EN undefined: fixed priority, M0 always wins a tie. LAST is still maintained but ignored. M1 may starve under continuous M0 traffic.

## Test plan
- Reset: assert RST mid-DATA with M0 reading -> M0_RDY stays 0; all outputs hold reset values; after release with M0_REQ still high, M0 completes 2 cycles after the first IDLE edge.
- Write then read: M0 writes 0xDEADBEEF to A=0x405 (WE=0xF), then reads 0x405 -> RAM_EN high exactly one cycle each time; M0_DO=0xDEADBEEF with M0_RDY on cycle k+1.
- Byte write: M1 writes 0x11223344 to A=0x003, then WE=0x2 data 0x0000AA00, then reads 0x003 -> M1_DO=0x1122AA44.
- Bank split: write 0xA5A5A5A5 to A=0x010 and 0x5A5A5A5A to A=0x410 -> reads return the respective values, with no cross-bank aliasing.
- Tie, RR build: M0 and M1 request continuously for 6 accesses -> grants alternate M0, M1, M0, M1, M0, M1 (LAST=1 after reset).
- Tie, non-RR build: same stimulus -> all 6 grants go to M0 and M1_RDY stays 0; when M0 drops REQ, M1 completes within 3 cycles.

Source files
------------

// File: rtl/ram_arbiter_2p.sv
// Two-master arbiter/sequencer for the dual-bank word RAM: IDLE -> ISSUE -> DATA.
// Define RAM_ARB_RR_EN for round-robin ties; otherwise M0 has fixed priority.
module ram_arbiter_2p #(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            M0_REQ,
    input  logic [DW/8-1:0] M0_WE,
    input  logic [AW-1:0]   M0_A,
    input  logic [DW-1:0]   M0_DI,
    output logic [DW-1:0]   M0_DO,
    output logic            M0_RDY,
    input  logic            M1_REQ,
    input  logic [DW/8-1:0] M1_WE,
    input  logic [AW-1:0]   M1_A,
    input  logic [DW-1:0]   M1_DI,
    output logic [DW-1:0]   M1_DO,
    output logic            M1_RDY,
    output logic            RAM_EN,
    output logic [DW/8-1:0] RAM_WE,
    output logic [AW-1:0]   RAM_A,
    output logic [DW-1:0]   RAM_DI,
    input  logic [DW-1:0]   RAM_DO
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DATA
    } state_t;

`ifdef RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    state_t state;
    logic   gnt;
    logic   last;
    logic   pick;

    // Tie resolution: round-robin favours whoever did not win last time.
    always_comb begin
        pick = 1'b0;
        if (M0_REQ && M1_REQ) begin
            pick = RR ? ~last : 1'b0;
        end else begin
            pick = M1_REQ;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            gnt    <= 1'b0;
            last   <= 1'b1;
            RAM_EN <= 1'b0;
            RAM_WE <= '0;
            RAM_A  <= '0;
            RAM_DI <= '0;
            M0_RDY <= 1'b0;
            M1_RDY <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (M0_REQ || M1_REQ) begin
                        state  <= ISSUE;
                        gnt    <= pick;
                        last   <= pick;
                        RAM_EN <= 1'b1;
                        RAM_WE <= pick ? M1_WE : M0_WE;
                        RAM_A  <= pick ? M1_A  : M0_A;
                        RAM_DI <= pick ? M1_DI : M0_DI;
                    end else begin
                        RAM_EN <= 1'b0;
                        RAM_WE <= '0;
                        RAM_A  <= '0;
                        RAM_DI <= '0;
                    end
                end
                ISSUE: begin
                    state  <= DATA;
                    RAM_EN <= 1'b0;
                    RAM_WE <= '0;
                    M0_RDY <= ~gnt;
                    M1_RDY <= gnt;
                end
                DATA: begin
                    state  <= IDLE;
                    M0_RDY <= 1'b0;
                    M1_RDY <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM read data arrives during DATA, so it is steered rather than registered.
    assign M0_DO = M0_RDY ? RAM_DO : '0;
    assign M1_DO = M1_RDY ? RAM_DO : '0;

endmodule
